ahb_master_arbiter: RTL
=======================

# ahb_master_arbiter

Shares the single AHB-Lite master port between the instruction-fetch requester (I) and the MEM-stage data requester (D). Accepts one transaction at a time, drives the address and data phases, and returns read data, completion and error to the owning requester. Sits between the pipeline/cache front ends and the system AHB-Lite interconnect.

## Interface
- ADDR_WIDTH, 32, address width of requester ports and HADDR
- DATA_WIDTH, 32, data width of wdata/rdata/HWDATA/HRDATA
- clk  in  1  core clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- i_req, d_req  in  1  transaction request; held until the matching gnt
- i_addr, d_addr  in  ADDR_WIDTH  byte address
- i_we, d_we  in  1  1 = write, 0 = read (I normally ties 0)
- i_wdata, d_wdata  in  DATA_WIDTH  write data
- i_gnt, d_gnt  out  1  one-cycle pulse: request latched
- i_done, d_done  out  1  one-cycle pulse: transaction complete
- i_err, d_err  out  1  valid with done; slave returned ERROR
- i_rdata, d_rdata  out  DATA_WIDTH  read data, valid with done; holds until next done to that port
- HADDR  out  ADDR_WIDTH  AHB address
- HTRANS  out  2  IDLE 2'b00 or NONSEQ 2'b10 only
- HWRITE  out  1  AHB direction
- HSIZE  out  3  constant 3'b010 (word)
- HBURST  out  3  constant 3'b000 (SINGLE)
- HWDATA  out  DATA_WIDTH  AHB write data
- HRDATA  in  DATA_WIDTH  AHB read data
- HREADY  in  1  AHB ready
- HRESP  in  1  AHB response, 1 = ERROR

## Operation
- FSM states: IDLE, ADDR, DATA. All outputs registered.
- IDLE: if any req, select winner, latch addr/we/wdata and owner, drive HADDR/HWRITE, HTRANS<=NONSEQ, pulse winner's gnt, go ADDR. No req: HTRANS stays IDLE.
- ADDR: HTRANS=NONSEQ held. On HREADY=1: HTRANS<=IDLE, HWDATA<=latched wdata, go DATA. HREADY=0: hold all.
- DATA: on HREADY=1: owner's rdata<=HRDATA (reads only; writes leave rdata unchanged), err<=HRESP, pulse owner's done, go IDLE. HREADY=0: hold; wait unbounded.
- Requester inputs ignored from gnt until that port's done; a req high during the done cycle is arbitrated normally in IDLE.
- Arbitration: fixed D-over-I priority (see Configuration for alternative).
- Reset values: state IDLE, HTRANS 2'b00, HADDR 0, HWRITE 0, HWDATA 0, all gnt/done/err 0, rdata 0, owner I, round-robin pointer = last owner I.
- Reset asserted mid-transaction: return to IDLE immediately, no done/err pulse, transaction discarded; requesters must reissue.

## Timing
- Zero-wait slave: req sampled at edge 0 -> gnt + NONSEQ in cycle 1 -> data phase cycle 2 -> done in cycle 3 -> next NONSEQ earliest cycle 4 (one bubble between transfers).
- Each HREADY=0 cycle in ADDR or DATA adds one cycle of latency.
- gnt and done are never asserted to both ports in the same cycle; at most one transaction outstanding.

## Configuration
- ROUND_ROBIN_EN defined: on simultaneous i_req and d_req, grant the port that did not own the previous transaction; lone request granted immediately. Pointer reset to I, so the first contested grant goes to D.
- ROUND_ROBIN_EN undefined: D always wins contested grants; I can be starved by back-to-back D traffic.

## Test plan
- Single read on D, addr 0x0000_1000, HRDATA 0xDEAD_BEEF, HREADY=1 -> d_gnt cycle 1, NONSEQ with HADDR 0x1000 cycle 1, d_done cycle 3, d_rdata 0xDEAD_BEEF, d_err 0.
- Single write on I, addr 0x20, wdata 0x1234_5678, HREADY low 2 cycles in DATA -> HWDATA 0x1234_5678 from cycle 2, HWRITE 1, i_done cycle 5.
- i_req and d_req held high continuously for 4 transactions -> without macro: D,D,D,D; with ROUND_ROBIN_EN: D,I,D,I.
- D read with HRESP=1 in DATA -> d_done and d_err pulse together, state back to IDLE, HTRANS 2'b00 next cycle.
- reset_n low during DATA with HREADY=0 -> all outputs to reset values asynchronously, no done pulse; first request after release granted normally.

Source files
------------

// File: rtl/ahb_master_arbiter_if.sv
// rtl/ahb_master_arbiter_if.sv - AHB-Lite master-side bus bundle for ahb_master_arbiter
// Purpose: groups the single-transfer AHB-Lite signals driven/observed by the arbiter.
// Ports (signals):
//   HADDR/HTRANS/HWRITE/HSIZE/HBURST/HWDATA : master -> slave
//   HRDATA/HREADY/HRESP                     : slave -> master
// Modports: master (arbiter side), slave (interconnect/bench side).
interface ahb_master_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic                  HREADY;
  logic                  HRESP;

  modport master (
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/ahb_master_arbiter.sv
// rtl/ahb_master_arbiter.sv - two-requester (I/D) arbiter onto one AHB-Lite master port
// Purpose: accepts one transaction at a time from the instruction (I) or data (D)
//   requester, runs its AHB address and data phases, and returns rdata/done/err
//   to the owner. Fixed D-over-I priority; define ROUND_ROBIN_EN to alternate
//   contested grants between the two ports instead.
// Ports:
//   clk, reset_n                 : clock, asynchronous active-low reset
//   i_/d_req, _addr, _we, _wdata : requester inputs, req held until gnt
//   i_/d_gnt, _done, _err        : one-cycle pulses (err valid with done)
//   i_/d_rdata                   : read data, held until next done to that port
//   ahb (master modport)         : AHB-Lite bus signals
module ahb_master_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_we,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  i_gnt,
  output logic                  i_done,
  output logic                  i_err,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_req,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic                  d_we,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_done,
  output logic                  d_err,
  output logic [DATA_WIDTH-1:0] d_rdata,
  ahb_master_arbiter_if.master  ahb
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;   // 1 = D, 0 = I; also the round-robin "last owner"
  logic [ADDR_WIDTH-1:0] haddr_q, haddr_d;
  logic                  hwrite_q, hwrite_d;
  logic [1:0]            htrans_q, htrans_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] hwdata_q, hwdata_d;
  logic                  i_gnt_q, i_gnt_d, d_gnt_q, d_gnt_d;
  logic                  i_done_q, i_done_d, d_done_q, d_done_d;
  logic                  i_err_q, i_err_d, d_err_q, d_err_d;
  logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic                  pick_d;             // winner of this cycle's arbitration, 1 = D

  always_comb begin
`ifdef ROUND_ROBIN_EN
    // Contested: give it to whoever did not own the previous transaction.
    if (i_req && d_req) pick_d = ~owner_q;
    else                pick_d = d_req;
`else
    pick_d = d_req;
`endif
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    haddr_d   = haddr_q;
    hwrite_d  = hwrite_q;
    htrans_d  = htrans_q;
    wdata_d   = wdata_q;
    hwdata_d  = hwdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_gnt_d   = 1'b0;
    d_gnt_d   = 1'b0;
    i_done_d  = 1'b0;
    d_done_d  = 1'b0;
    i_err_d   = 1'b0;
    d_err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_req || d_req) begin
          owner_d  = pick_d;
          haddr_d  = pick_d ? d_addr  : i_addr;
          hwrite_d = pick_d ? d_we    : i_we;
          wdata_d  = pick_d ? d_wdata : i_wdata;
          htrans_d = HTRANS_NONSEQ;
          d_gnt_d  = pick_d;
          i_gnt_d  = ~pick_d;
          state_d  = S_ADDR;
        end
      end
      S_ADDR: begin
        if (ahb.HREADY) begin
          htrans_d = HTRANS_IDLE;
          hwdata_d = wdata_q;
          state_d  = S_DATA;
        end
      end
      S_DATA: begin
        if (ahb.HREADY) begin
          if (owner_q) begin
            d_done_d = 1'b1;
            d_err_d  = ahb.HRESP;
            if (!hwrite_q) d_rdata_d = ahb.HRDATA;
          end else begin
            i_done_d = 1'b1;
            i_err_d  = ahb.HRESP;
            if (!hwrite_q) i_rdata_d = ahb.HRDATA;
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      owner_q   <= 1'b0;
      haddr_q   <= '0;
      hwrite_q  <= 1'b0;
      htrans_q  <= HTRANS_IDLE;
      wdata_q   <= '0;
      hwdata_q  <= '0;
      i_gnt_q   <= 1'b0;
      d_gnt_q   <= 1'b0;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      i_err_q   <= 1'b0;
      d_err_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      haddr_q   <= haddr_d;
      hwrite_q  <= hwrite_d;
      htrans_q  <= htrans_d;
      wdata_q   <= wdata_d;
      hwdata_q  <= hwdata_d;
      i_gnt_q   <= i_gnt_d;
      d_gnt_q   <= d_gnt_d;
      i_done_q  <= i_done_d;
      d_done_q  <= d_done_d;
      i_err_q   <= i_err_d;
      d_err_q   <= d_err_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign ahb.HADDR  = haddr_q;
  assign ahb.HTRANS = htrans_q;
  assign ahb.HWRITE = hwrite_q;
  assign ahb.HSIZE  = 3'b010;
  assign ahb.HBURST = 3'b000;
  assign ahb.HWDATA = hwdata_q;

  assign i_gnt   = i_gnt_q;
  assign d_gnt   = d_gnt_q;
  assign i_done  = i_done_q;
  assign d_done  = d_done_q;
  assign i_err   = i_err_q;
  assign d_err   = d_err_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;

endmodule
